arbitro_contador: RTL and testbench
===================================

Name: arbitro_contador

Overview:
- Shares one `contador` increment port (`push`, 6-bit `cuenta`) among N push requesters.
- Each requester keeps a small pending-event credit, so simultaneous pushes are never lost while within capacity.
- A round-robin scheduler issues one registered `push` per cycle, tagged with the selected requester index on `sel`.
- A flush handshake drains all pending credits and signals completion; the block sits between the FIFO push sources and the counter bank.

Parameters:
- N, 4, number of requesters (power of two, 2..8)
- SEL_W, 2, width of sel = log2(N)
- PEND_W, 3, width of each pending-credit counter (max 2^PEND_W-1 = 7)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- push_req  input  N  one-cycle push event per requester; may be high on consecutive cycles
- flush  input  1  request to drain all pending credits; sampled in IDLE/SERVE only
- push  output  1  registered increment strobe to the counter bank
- sel  output  SEL_W  registered index of the counter incremented with push
- pend_any  output  1  registered; high while any credit is non-zero
- done  output  1  one-cycle pulse when a flush completes
- error  output  N  sticky per-requester overflow flag

Behaviour:
- Reset (async, high): push=0, sel=0, pend_any=0, done=0, error=0, all pend[i]=0, rr_ptr=0, state=IDLE. Reset mid-drain discards all credits; no done pulse.
- Credit update per cycle:
  - pend[i] <= pend[i] + push_req[i] - gnt[i].
  - req and gnt on the same i in the same cycle leaves pend[i] unchanged.
  - pend[i] at max with push_req[i] and no gnt[i]: the event is dropped, pend stays at max, error[i] <= 1 until reset.
- Arbitration (combinational on registered pend):
  - Candidates are all i with pend[i] != 0.
  - gnt is the first candidate at or after rr_ptr, circularly.
  - When gnt is non-zero: rr_ptr <= granted+1 mod N, push <= 1, sel <= granted.
  - Otherwise push <= 0 and sel holds its value.
- Latency: push_req at edge t -> pend at t+1 -> push/sel visible after edge t+2, uncontended.
- Throughput: one push per cycle, sustained. With all N requesters busy, each is served every N cycles.
- FSM:
  - IDLE: no credits.
    - Go to SERVE when any pend != 0 or any push_req.
    - flush with nothing pending and no push_req: go to DONE.
    - flush otherwise: go to DRAIN.
  - SERVE:
    - Go to IDLE when all pend==0 and no push_req.
    - flush: go to DRAIN.
  - DRAIN:
    - Keeps granting.
    - push_req is still accepted and extends the drain.
    - flush is ignored.
    - When all pend==0 and no push_req: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. flush held high re-enters DRAIN only after IDLE, i.e. one pulse per flush request.
- pend_any is the registered OR of all credits, updated the same edge as pend.
- Widths:
  - Credit arithmetic uses PEND_W bits with explicit saturation; wrap-around is never allowed.
  - sel is zero-extended if consumed as a 6-bit address.

Optional Feature:
- Macro: ARBITRO_PRIORIDAD_FIJA_EN.
- Defined: fixed priority, lowest index wins, rr_ptr is not implemented and stays 0. Starvation of high indices is allowed.
- Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Package `arbitro_pkg`:
  - FSM state encoding localparams: IDLE=2'd0, SERVE=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Defaults for N, SEL_W, PEND_W.
  - PEND_MAX constant.
- Sub-module `contador_pendiente`: one saturating up/down credit counter with the sticky error flag, instantiated N times.
- Round-robin select and FSM stay in the top module.
- A behavioural and a synthesized version are both compared in the bench, cycle by cycle.

Test Plan:
- Reset asserted mid-cycle while pend[2]=5 -> all outputs 0 immediately, pend cleared, no push after release.
- Single push_req[1] pulse -> exactly one push with sel=1, two cycles later; pend_any high for one cycle.
- push_req=4'b1111 for 1 cycle -> push on 4 consecutive cycles, sel 0,1,2,3; next burst starts from rr_ptr.
- push_req[3] held 10 cycles while requesters 0-2 are each fed once per cycle -> pend[3] saturates at 7, error[3]=1 sticky, other error bits 0.
- flush with pend={2,0,1,0} -> 3 pushes, then done pulses exactly once; flush while IDLE empty -> done next cycle.
- With ARBITRO_PRIORIDAD_FIJA_EN defined: push_req=4'b1011 held 6 cycles -> sel stays 0 while pend[0]!=0.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared constants and FSM encoding for the arbitro_contador push arbiter.
package arbitro_pkg;

   localparam int N_DEF      = 4;
   localparam int SEL_W_DEF  = 2;
   localparam int PEND_W_DEF = 3;

   function automatic int pend_max(input int w);
      return (1 << w) - 1;
   endfunction

   localparam int PEND_MAX = pend_max(PEND_W_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/contador_pendiente.sv
// One requester's pending-event credit: saturating up/down counter with a sticky
// overflow flag raised when an event arrives at full credit and is not drained.
module contador_pendiente
   import arbitro_pkg::*;
#(
   parameter int PEND_W = PEND_W_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              inc_i,
   input  logic              dec_i,
   output logic [PEND_W-1:0] pend_o,
   output logic              nonzero_d_o,
   output logic              error_o
);

   localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(pend_max(PEND_W));

   logic [PEND_W-1:0] pend_q, pend_d;
   logic              error_q, error_d;

   always_comb begin
      pend_d  = pend_q;
      error_d = error_q;
      if (inc_i && !dec_i) begin
         if (pend_q == PEND_TOP) error_d = 1'b1;
         else                    pend_d  = pend_q + PEND_W'(1);
      end else if (dec_i && !inc_i && (pend_q != '0)) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pend_q  <= '0;
         error_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         error_q <= error_d;
      end
   end

   assign pend_o      = pend_q;
   assign nonzero_d_o = (pend_d != '0);
   assign error_o     = error_q;

endmodule

// File: rtl/arbitro_contador.sv
// Shares one counter increment port among N push requesters with per-requester credits.
// Build option ARBITRO_PRIORIDAD_FIJA_EN: fixed priority (lowest index wins) instead of round-robin.
//
// state | meaning
// IDLE  | no credits, waiting for events or flush
// SERVE | granting pending credits
// DRAIN | flush accepted, granting until all credits are gone
// DONE  | one-cycle flush completion pulse
module arbitro_contador
   import arbitro_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int SEL_W  = SEL_W_DEF,
   parameter int PEND_W = PEND_W_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N-1:0]     push_req_i,
   input  logic             flush_i,
   output logic             push_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             pend_any_o,
   output logic             done_o,
   output logic [N-1:0]     error_o
);

   logic [PEND_W-1:0] pend [N];
   logic [N-1:0]      cand;
   logic [N-1:0]      nonzero_d;
   logic [N-1:0]      gnt;
   logic [SEL_W-1:0]  gnt_idx;
   logic [SEL_W-1:0]  idx;
   logic              found;
   logic [SEL_W-1:0]  rr_ptr;

   logic              push_q, push_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              pend_any_q;
   state_e            state_q, state_d;
   logic              busy;

   for (genvar i = 0; i < N; i++) begin : g_cnt
      contador_pendiente #(.PEND_W(PEND_W)) u_cnt (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .inc_i       (push_req_i[i]),
         .dec_i       (gnt[i]),
         .pend_o      (pend[i]),
         .nonzero_d_o (nonzero_d[i]),
         .error_o     (error_o[i])
      );
      assign cand[i] = (pend[i] != '0);
   end

   // Search starts at rr_ptr; SEL_W-bit addition wraps because N is a power of two.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = rr_ptr + SEL_W'(k);
         if (!found && cand[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (found) gnt[gnt_idx] = 1'b1;
   end

`ifdef ARBITRO_PRIORIDAD_FIJA_EN
   assign rr_ptr = '0;
`else
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found) rr_ptr_d = gnt_idx + SEL_W'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) rr_ptr_q <= '0;
      else         rr_ptr_q <= rr_ptr_d;
   end

   assign rr_ptr = rr_ptr_q;
`endif

   always_comb begin
      push_d = found;
      sel_d  = found ? gnt_idx : sel_q;
   end

   assign busy = (|cand) || (|push_req_i);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (flush_i)   state_d = busy ? DRAIN : DONE;
            else if (busy) state_d = SERVE;
         end
         SERVE: begin
            if (flush_i)    state_d = DRAIN;
            else if (!busy) state_d = IDLE;
         end
         DRAIN: begin
            if (!busy) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         push_q     <= 1'b0;
         sel_q      <= '0;
         pend_any_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         push_q     <= push_d;
         sel_q      <= sel_d;
         pend_any_q <= |nonzero_d;
         state_q    <= state_d;
      end
   end

   assign push_o     = push_q;
   assign sel_o      = sel_q;
   assign pend_any_o = pend_any_q;
   assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_arbitro_contador.sv
// Bench for arbitro_contador: expected push/sel events and done pulses are queued
// with their due cycle when stimulus is driven, then popped against what the DUT emits.
module tb_arbitro_contador;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] push_req = '0;
   logic       flush = 1'b0;
   logic       push_o;
   logic [1:0] sel_o;
   logic       pend_any_o;
   logic       done_o;
   logic [3:0] error_o;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int cyc      = 0;
   int s;
   int es, ec, os, oc;

   int obs_sel[$];
   int obs_cyc[$];
   int done_cyc[$];
   int exp_sel[$];
   int exp_cyc[$];

   int sat_tbl[19] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 3, 3, 3, 3, 3};
   int flush_tbl[4];

   arbitro_contador #(.N(4), .SEL_W(2), .PEND_W(3)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .push_req_i (push_req),
      .flush_i    (flush),
      .push_o     (push_o),
      .sel_o      (sel_o),
      .pend_any_o (pend_any_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (push_o) begin
         obs_sel.push_back(int'(sel_o));
         obs_cyc.push_back(cyc);
      end
      if (done_o) done_cyc.push_back(cyc);
   endtask

   task automatic clear_q();
      obs_sel.delete(); obs_cyc.delete(); done_cyc.delete();
      exp_sel.delete(); exp_cyc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; push_req = '0; flush = 1'b0;
      repeat (2) step();
      vec_cnt++;
      if ({push_o, sel_o, pend_any_o, done_o, error_o} !== 9'b0) begin
         miss_cnt++;
         $display("FAIL reset_state: got %b, expected 000000000", {push_o, sel_o, pend_any_o, done_o, error_o});
      end
      rst = 1'b0;
      push_req = 4'b1111;
      repeat (6) step();
      vec_cnt++;
      if (pend_any_o !== 1'b1) begin
         miss_cnt++;
         $display("FAIL reset_build_pend_any: got %b, expected 1", pend_any_o);
      end
      push_req = '0; flush = 1'b1;
      step();
      flush = 1'b0;
      #3 rst = 1'b1;
      #1;
      vec_cnt++;
      if ({push_o, sel_o, pend_any_o, done_o, error_o} !== 9'b0) begin
         miss_cnt++;
         $display("FAIL reset_async: got %b, expected 000000000", {push_o, sel_o, pend_any_o, done_o, error_o});
      end
      step();
      rst = 1'b0;
      clear_q();
      repeat (8) step();
      vec_cnt++;
      if (obs_sel.size() != 0 || done_cyc.size() != 0 || pend_any_o !== 1'b0) begin
         miss_cnt++;
         $display("FAIL reset_after_release: pushes %0d dones %0d pend_any %b, expected 0 0 0",
                  obs_sel.size(), done_cyc.size(), pend_any_o);
      end
   endtask

   task automatic test_burst();
      clear_q();
      s = cyc;
      push_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin exp_sel.push_back(i); exp_cyc.push_back(s + 2 + i); end
      step();
      push_req = '0;
      repeat (5) step();
      s = cyc;
      push_req = 4'b0010;
      exp_sel.push_back(1); exp_cyc.push_back(s + 2);
      step();
      push_req = '0;
      step();
      push_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin exp_sel.push_back((i + 2) % 4); exp_cyc.push_back(s + 4 + i); end
      step();
      push_req = '0;
      repeat (6) step();
      while (exp_sel.size() > 0 && obs_sel.size() > 0) begin
         es = exp_sel.pop_front(); ec = exp_cyc.pop_front();
         os = obs_sel.pop_front(); oc = obs_cyc.pop_front();
         vec_cnt++;
         if (os !== es || oc !== ec) begin
            miss_cnt++;
            $display("FAIL burst_push: got sel %0d at cycle %0d, expected sel %0d at cycle %0d", os, oc, es, ec);
         end
      end
      vec_cnt++;
      if (exp_sel.size() != 0 || obs_sel.size() != 0) begin
         miss_cnt++;
         $display("FAIL burst_count: %0d expected unmatched, %0d extra pushes, expected 0 0", exp_sel.size(), obs_sel.size());
      end
   endtask

   task automatic test_single();
      clear_q();
      s = cyc;
      push_req = 4'b0010;
      exp_sel.push_back(1); exp_cyc.push_back(s + 2);
      step();
      vec_cnt++;
      if (pend_any_o !== 1'b1 || push_o !== 1'b0) begin
         miss_cnt++;
         $display("FAIL single_t1: got pend_any %b push %b, expected 1 0", pend_any_o, push_o);
      end
      push_req = '0;
      step();
      vec_cnt++;
      if (pend_any_o !== 1'b0) begin
         miss_cnt++;
         $display("FAIL single_t2_pend_any: got %b, expected 0", pend_any_o);
      end
      repeat (5) step();
      while (exp_sel.size() > 0 && obs_sel.size() > 0) begin
         es = exp_sel.pop_front(); ec = exp_cyc.pop_front();
         os = obs_sel.pop_front(); oc = obs_cyc.pop_front();
         vec_cnt++;
         if (os !== es || oc !== ec) begin
            miss_cnt++;
            $display("FAIL single_push: got sel %0d at cycle %0d, expected sel %0d at cycle %0d", os, oc, es, ec);
         end
      end
      vec_cnt++;
      if (exp_sel.size() != 0 || obs_sel.size() != 0) begin
         miss_cnt++;
         $display("FAIL single_count: %0d expected unmatched, %0d extra pushes, expected 0 0", exp_sel.size(), obs_sel.size());
      end
   endtask

   task automatic test_flush();
      clear_q();
      s = cyc;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      flush_tbl = '{0, 0, 2, 2};
`else
      flush_tbl = '{2, 0, 2, 0};
`endif
      for (int i = 0; i < 4; i++) begin exp_sel.push_back(flush_tbl[i]); exp_cyc.push_back(s + 2 + i); end
      push_req = 4'b0101;
      step();
      step();
      push_req = '0; flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (5) step();
      while (exp_sel.size() > 0 && obs_sel.size() > 0) begin
         es = exp_sel.pop_front(); ec = exp_cyc.pop_front();
         os = obs_sel.pop_front(); oc = obs_cyc.pop_front();
         vec_cnt++;
         if (os !== es || oc !== ec) begin
            miss_cnt++;
            $display("FAIL flush_push: got sel %0d at cycle %0d, expected sel %0d at cycle %0d", os, oc, es, ec);
         end
      end
      vec_cnt++;
      if (exp_sel.size() != 0 || obs_sel.size() != 0) begin
         miss_cnt++;
         $display("FAIL flush_count: %0d expected unmatched, %0d extra pushes, expected 0 0", exp_sel.size(), obs_sel.size());
      end
      vec_cnt++;
      if (done_cyc.size() != 1 || done_cyc[0] != s + 6) begin
         miss_cnt++;
         $display("FAIL flush_done: got %0d pulses first at %0d, expected 1 pulse at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, s + 6);
      end
   endtask

   task automatic test_flush_idle();
      clear_q();
      s = cyc;
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (3) step();
      vec_cnt++;
      if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin
         miss_cnt++;
         $display("FAIL flush_idle_done: got %0d pulses first at %0d, expected 1 pulse at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, s + 1);
      end
      vec_cnt++;
      if (obs_sel.size() != 0) begin
         miss_cnt++;
         $display("FAIL flush_idle_push: got %0d pushes, expected 0", obs_sel.size());
      end
   endtask

   task automatic test_saturate();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_q();
      s = cyc;
      for (int i = 0; i < 19; i++) begin exp_sel.push_back(sat_tbl[i]); exp_cyc.push_back(s + 2 + i); end
      for (int k = 1; k <= 10; k++) begin
         push_req = 4'b1000 | (4'b0001 << ((k - 1) % 3));
         step();
         if (k == 9) begin
            vec_cnt++;
            if (error_o !== 4'b0000) begin
               miss_cnt++;
               $display("FAIL sat_at_max_no_error: got %b, expected 0000", error_o);
            end
         end
         if (k == 10) begin
            vec_cnt++;
            if (error_o !== 4'b1000) begin
               miss_cnt++;
               $display("FAIL sat_overflow: got %b, expected 1000", error_o);
            end
         end
      end
      push_req = '0;
      repeat (12) step();
      while (exp_sel.size() > 0 && obs_sel.size() > 0) begin
         es = exp_sel.pop_front(); ec = exp_cyc.pop_front();
         os = obs_sel.pop_front(); oc = obs_cyc.pop_front();
         vec_cnt++;
         if (os !== es || oc !== ec) begin
            miss_cnt++;
            $display("FAIL sat_push: got sel %0d at cycle %0d, expected sel %0d at cycle %0d", os, oc, es, ec);
         end
      end
      vec_cnt++;
      if (exp_sel.size() != 0 || obs_sel.size() != 0) begin
         miss_cnt++;
         $display("FAIL sat_count: %0d expected unmatched, %0d extra pushes, expected 0 0", exp_sel.size(), obs_sel.size());
      end
      vec_cnt++;
      if (error_o !== 4'b1000 || pend_any_o !== 1'b0) begin
         miss_cnt++;
         $display("FAIL sat_sticky: got error %b pend_any %b, expected 1000 0", error_o, pend_any_o);
      end
   endtask

   task automatic test_fixed();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_q();
      s = cyc;
      for (int i = 0; i < 18; i++) begin
         exp_sel.push_back((i < 6) ? 0 : ((i < 12) ? 1 : 3));
         exp_cyc.push_back(s + 2 + i);
      end
      push_req = 4'b1011;
      repeat (6) step();
      push_req = '0;
      repeat (15) step();
      while (exp_sel.size() > 0 && obs_sel.size() > 0) begin
         es = exp_sel.pop_front(); ec = exp_cyc.pop_front();
         os = obs_sel.pop_front(); oc = obs_cyc.pop_front();
         vec_cnt++;
         if (os !== es || oc !== ec) begin
            miss_cnt++;
            $display("FAIL fixed_push: got sel %0d at cycle %0d, expected sel %0d at cycle %0d", os, oc, es, ec);
         end
      end
      vec_cnt++;
      if (exp_sel.size() != 0 || obs_sel.size() != 0 || error_o !== 4'b0000) begin
         miss_cnt++;
         $display("FAIL fixed_count: %0d unmatched, %0d extra, error %b, expected 0 0 0000",
                  exp_sel.size(), obs_sel.size(), error_o);
      end
   endtask

   initial begin
      test_reset();
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      test_single();
      test_flush();
      test_flush_idle();
      test_fixed();
`else
      test_burst();
      test_single();
      test_flush();
      test_flush_idle();
      test_saturate();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
      $fatal(1, "time limit");
   end

endmodule
